mc_responder: RTL and testbench

Behavioural memory-controller responder for simulation and FPGA bring-up of the PHOLD engine. It accepts 8-byte read/write requests on the core-side MC request interface, services them against a small internal memory, and returns RD8_DATA / WR_CMP responses with the request's rtnctl echoed after a fixed latency. It sits where the vendor MC port would attach, so the event-processing cores run unmodified.

---
 rtl/mc_responder_pkg.sv | 26 ++
 rtl/mc_resp_fifo.sv | 66 ++++++
 rtl/mc_responder.sv | 123 ++++++++++++
 tb/tb_mc_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_responder_pkg.sv
// Shared AEMC/MCAE message encodings and request decode for the MC responder.
// Values mirror the AEMC message definitions used by the PHOLD cores.
package mc_responder_pkg;

    localparam logic [2:0] AEMC_CMD_IDLE     = 3'd0;
    localparam logic [2:0] AEMC_CMD_RD8      = 3'd1;
    localparam logic [2:0] AEMC_CMD_WR8      = 3'd2;
    localparam logic [2:0] MCAE_CMD_RD8_DATA = 3'd2;
    localparam logic [2:0] MCAE_CMD_WR_CMP   = 3'd3;
    localparam logic [1:0] MC_SIZE_QUAD      = 2'd3;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_READ,
        REQ_WRITE,
        REQ_BAD
    } req_kind_e;

    function automatic req_kind_e decode_cmd(input logic vld, input logic [2:0] cmd);
        if (!vld || cmd == AEMC_CMD_IDLE) return REQ_NONE;
        if (cmd == AEMC_CMD_RD8) return REQ_READ;
        if (cmd == AEMC_CMD_WR8) return REQ_WRITE;
        return REQ_BAD;
    endfunction

endpackage

// File: rtl/mc_resp_fifo.sv
// Pending-response FIFO: payload storage, per-entry age (saturating at LATENCY),
// occupancy and full/empty flags. Head is ready once its age reaches LATENCY.
module mc_resp_fifo
    import mc_responder_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 4,
    parameter int PW      = 99
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [PW-1:0]            i_push_data,
    input  logic                     i_pop,
    output logic [PW-1:0]            o_head_data,
    output logic                     o_head_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] AGE_MAX = 4'(LATENCY);

    logic [PW-1:0] r_data [DEPTH];
    logic [3:0]    r_age  [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full       = (r_count == (AW+1)'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign w_pop_ok     = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push needs when full.
    assign w_push_ok    = i_push && (!o_full || w_pop_ok);
    assign o_head_data  = r_data[r_rd_ptr];
    assign o_head_ready = !o_empty && (r_age[r_rd_ptr] == AGE_MAX);
    assign o_count      = r_count;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_data[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push_ok && r_wr_ptr == i[AW-1:0]) r_age[i] <= 4'd1;
                else if (r_age[i] != AGE_MAX)           r_age[i] <= r_age[i] + 4'd1;
            end
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mc_responder.sv
// Behavioural MC responder: 8-byte RD8/WR8 against internal memory, fixed-latency
// in-order responses. Define MC_RESP_STALL_INJECT_EN to inject periodic stalls.
module mc_responder
    import mc_responder_pkg::*;
#(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int MEM_AW          = 8,
    parameter int LATENCY         = 4,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mc_rq_vld,
    input  logic [2:0]                 mc_rq_cmd,
    input  logic [3:0]                 mc_rq_scmd,
    input  logic [47:0]                mc_rq_vadr,
    input  logic [1:0]                 mc_rq_size,
    input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic [63:0]                mc_rq_data,
    input  logic                       mc_rq_flush,
    output logic                       mc_rq_stall,
    output logic                       mc_rs_vld,
    output logic [2:0]                 mc_rs_cmd,
    output logic [3:0]                 mc_rs_scmd,
    output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    output logic [63:0]                mc_rs_data,
    input  logic                       mc_rs_stall,
    output logic                       err
);
    localparam int PW = 3 + MC_RTNCTL_WIDTH + 64;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0]                r_mem [2**MEM_AW];
    logic                       r_err;
    logic                       r_rs_vld;
    logic [2:0]                 r_rs_cmd;
    logic [MC_RTNCTL_WIDTH-1:0] r_rs_rtnctl;
    logic [63:0]                r_rs_data;

    req_kind_e                  w_kind;
    logic                       w_push_req;
    logic                       w_bad_fmt;
    logic                       w_drop;
    logic                       w_issue;
    logic                       w_inject;
    logic [MEM_AW-1:0]          w_idx;
    logic [2:0]                 w_push_cmd;
    logic [63:0]                w_push_dat;
    logic [PW-1:0]              w_head;
    logic                       w_head_ready;
    logic [CW-1:0]              w_count;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_unused;

    assign w_kind     = decode_cmd(mc_rq_vld, mc_rq_cmd);
    assign w_push_req = (w_kind == REQ_READ) || (w_kind == REQ_WRITE);
    assign w_idx      = mc_rq_vadr[MEM_AW+2:3];
    assign w_bad_fmt  = w_push_req && ((mc_rq_vadr[2:0] != 3'd0) || (mc_rq_size != MC_SIZE_QUAD));
    assign w_issue    = w_head_ready && !mc_rs_stall && !w_inject;
    assign w_drop     = w_push_req && w_full && !w_issue;
    assign w_push_cmd = (w_kind == REQ_READ) ? MCAE_CMD_RD8_DATA : MCAE_CMD_WR_CMP;
    assign w_push_dat = (w_kind == REQ_READ) ? r_mem[w_idx] : 64'd0;
    assign w_unused   = ^{mc_rq_scmd, mc_rq_flush, mc_rq_vadr[47:MEM_AW+3], w_empty};

    mc_resp_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .LATENCY (LATENCY),
        .PW      (PW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push_req),
        .i_push_data  ({w_push_cmd, mc_rq_rtnctl, w_push_dat}),
        .i_pop        (w_issue),
        .o_head_data  (w_head),
        .o_head_ready (w_head_ready),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Memory is deliberately not reset; a dropped write leaves it untouched.
    always_ff @(posedge clk) begin
        if (w_kind == REQ_WRITE && !w_drop) r_mem[w_idx] <= mc_rq_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_rs_vld    <= 1'b0;
            r_rs_cmd    <= '0;
            r_rs_rtnctl <= '0;
            r_rs_data   <= '0;
        end else begin
            if (w_kind == REQ_BAD || w_bad_fmt || w_drop) r_err <= 1'b1;
            r_rs_vld <= w_issue;
            if (w_issue) {r_rs_cmd, r_rs_rtnctl, r_rs_data} <= w_head;
        end
    end

`ifdef MC_RESP_STALL_INJECT_EN
    logic [3:0] r_inj_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_inj_cnt <= 4'd0;
        else     r_inj_cnt <= r_inj_cnt + 4'd1;
    end

    assign w_inject = (r_inj_cnt >= 4'd14);
`else
    assign w_inject = 1'b0;
`endif

    assign mc_rq_stall  = (w_count >= CW'(FIFO_DEPTH - 2)) || w_inject;
    assign mc_rs_vld    = r_rs_vld;
    assign mc_rs_cmd    = r_rs_cmd;
    assign mc_rs_scmd   = 4'd0;
    assign mc_rs_rtnctl = r_rs_rtnctl;
    assign mc_rs_data   = r_rs_data;
    assign err          = r_err;

endmodule

// File: tb/tb_mc_responder.sv
// Directed testbench for mc_responder (LATENCY=4, FIFO_DEPTH=8).
// Define MC_RESP_STALL_INJECT_EN to run the stall-injection scenario instead.
module tb_mc_responder;
    import mc_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mc_rq_vld;
    logic [2:0]  mc_rq_cmd;
    logic [3:0]  mc_rq_scmd;
    logic [47:0] mc_rq_vadr;
    logic [1:0]  mc_rq_size;
    logic [31:0] mc_rq_rtnctl;
    logic [63:0] mc_rq_data;
    logic        mc_rq_flush;
    logic        mc_rq_stall;
    logic        mc_rs_vld;
    logic [2:0]  mc_rs_cmd;
    logic [3:0]  mc_rs_scmd;
    logic [31:0] mc_rs_rtnctl;
    logic [63:0] mc_rs_data;
    logic        mc_rs_stall;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_responder #(
        .MC_RTNCTL_WIDTH (32),
        .MEM_AW          (8),
        .LATENCY         (4),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mc_rq_vld    (mc_rq_vld),
        .mc_rq_cmd    (mc_rq_cmd),
        .mc_rq_scmd   (mc_rq_scmd),
        .mc_rq_vadr   (mc_rq_vadr),
        .mc_rq_size   (mc_rq_size),
        .mc_rq_rtnctl (mc_rq_rtnctl),
        .mc_rq_data   (mc_rq_data),
        .mc_rq_flush  (mc_rq_flush),
        .mc_rq_stall  (mc_rq_stall),
        .mc_rs_vld    (mc_rs_vld),
        .mc_rs_cmd    (mc_rs_cmd),
        .mc_rs_scmd   (mc_rs_scmd),
        .mc_rs_rtnctl (mc_rs_rtnctl),
        .mc_rs_data   (mc_rs_data),
        .mc_rs_stall  (mc_rs_stall),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mc_rq_vld    = 1'b0;
        mc_rq_cmd    = AEMC_CMD_IDLE;
        mc_rq_scmd   = 4'd0;
        mc_rq_vadr   = 48'd0;
        mc_rq_size   = MC_SIZE_QUAD;
        mc_rq_rtnctl = 32'd0;
        mc_rq_data   = 64'd0;
        mc_rq_flush  = 1'b0;
    endtask

    task automatic drive(input logic [2:0] cmd, input logic [47:0] vadr, input logic [1:0] size,
                         input logic [31:0] rtn, input logic [63:0] data);
        mc_rq_vld    = 1'b1;
        mc_rq_cmd    = cmd;
        mc_rq_vadr   = vadr;
        mc_rq_size   = size;
        mc_rq_rtnctl = rtn;
        mc_rq_data   = data;
        mc_rq_scmd   = 4'hA;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        mc_rs_stall = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (mc_rs_vld !== 1'b0)    begin n_err++; $display("FAIL reset_rs_vld got %b want 0", mc_rs_vld); end
        n_vec++; if (mc_rs_cmd !== 3'd0)    begin n_err++; $display("FAIL reset_rs_cmd got %0d want 0", mc_rs_cmd); end
        n_vec++; if (mc_rs_rtnctl !== 32'd0) begin n_err++; $display("FAIL reset_rs_rtnctl got %h want 0", mc_rs_rtnctl); end
        n_vec++; if (mc_rs_data !== 64'd0)  begin n_err++; $display("FAIL reset_rs_data got %h want 0", mc_rs_data); end
        n_vec++; if (mc_rs_scmd !== 4'd0)   begin n_err++; $display("FAIL reset_rs_scmd got %h want 0", mc_rs_scmd); end
        n_vec++; if (mc_rq_stall !== 1'b0)  begin n_err++; $display("FAIL reset_rq_stall got %b want 0", mc_rq_stall); end
        n_vec++; if (err !== 1'b0)          begin n_err++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wr_rd();
        drive(AEMC_CMD_WR8, 48'h40, MC_SIZE_QUAD, 32'h5, 64'hDEAD_BEEF);
        tick();
        drive(AEMC_CMD_RD8, 48'h40, MC_SIZE_QUAD, 32'h7, 64'd0);
        tick();
        idle();
        tick();
        tick();
        n_vec++; if (mc_rs_vld !== 1'b0) begin n_err++; $display("FAIL wr_rd_early got vld %b want 0", mc_rs_vld); end
        tick();
        n_vec++; if (mc_rs_vld !== 1'b1)          begin n_err++; $display("FAIL wr_cmp_vld got %b want 1", mc_rs_vld); end
        n_vec++; if (mc_rs_cmd !== MCAE_CMD_WR_CMP) begin n_err++; $display("FAIL wr_cmp_cmd got %0d want %0d", mc_rs_cmd, MCAE_CMD_WR_CMP); end
        n_vec++; if (mc_rs_rtnctl !== 32'h5)      begin n_err++; $display("FAIL wr_cmp_rtnctl got %h want 5", mc_rs_rtnctl); end
        n_vec++; if (mc_rs_data !== 64'd0)        begin n_err++; $display("FAIL wr_cmp_data got %h want 0", mc_rs_data); end
        tick();
        n_vec++; if (mc_rs_vld !== 1'b1)            begin n_err++; $display("FAIL rd_vld got %b want 1", mc_rs_vld); end
        n_vec++; if (mc_rs_cmd !== MCAE_CMD_RD8_DATA) begin n_err++; $display("FAIL rd_cmd got %0d want %0d", mc_rs_cmd, MCAE_CMD_RD8_DATA); end
        n_vec++; if (mc_rs_rtnctl !== 32'h7)        begin n_err++; $display("FAIL rd_rtnctl got %h want 7", mc_rs_rtnctl); end
        n_vec++; if (mc_rs_data !== 64'hDEAD_BEEF)  begin n_err++; $display("FAIL rd_data got %h want deadbeef", mc_rs_data); end
        tick();
        n_vec++; if (mc_rs_vld !== 1'b0) begin n_err++; $display("FAIL wr_rd_tail got vld %b want 0", mc_rs_vld); end
        n_vec++; if (err !== 1'b0)       begin n_err++; $display("FAIL wr_rd_err got %b want 0", err); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            drive(AEMC_CMD_WR8, 48'(i * 8), MC_SIZE_QUAD, 32'(32'h200 + i), 64'(64'h1000 + i));
            tick();
        end
        idle();
        repeat (12) tick();
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL prefill_err got %b want 0", err); end
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(AEMC_CMD_RD8, 48'(i * 8), MC_SIZE_QUAD, 32'(32'h100 + i), 64'd0);
            tick();
            n_vec++;
            if (mc_rq_stall !== (i >= 5)) begin
                n_err++; $display("FAIL rq_stall_occ%0d got %b want %b", i + 1, mc_rq_stall, (i >= 5));
            end
        end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL full8_err got %b want 0", err); end
        drive(AEMC_CMD_RD8, 48'h40, MC_SIZE_QUAD, 32'h1FF, 64'd0);
        tick();
        idle();
        n_vec++; if (err !== 1'b1)       begin n_err++; $display("FAIL overflow_err got %b want 1", err); end
        n_vec++; if (mc_rs_vld !== 1'b0) begin n_err++; $display("FAIL stalled_vld got %b want 0", mc_rs_vld); end
        repeat (3) tick();
        mc_rs_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (mc_rs_vld !== 1'b1 || mc_rs_rtnctl !== 32'(32'h100 + i) || mc_rs_data !== 64'(64'h1000 + i)) begin
                n_err++; $display("FAIL drain%0d got vld %b rtn %h data %h want 1 %h %h", i, mc_rs_vld,
                                  mc_rs_rtnctl, mc_rs_data, 32'h100 + i, 64'h1000 + i);
            end
        end
        tick();
        n_vec++; if (mc_rs_vld !== 1'b0)   begin n_err++; $display("FAIL dropped_resp got vld %b want 0", mc_rs_vld); end
        n_vec++; if (mc_rq_stall !== 1'b0) begin n_err++; $display("FAIL drained_stall got %b want 0", mc_rq_stall); end
    endtask

    task automatic test_err();
        int seen;
        do_reset();
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared got %b want 0", err); end
        drive(AEMC_CMD_RD8, 48'h43, MC_SIZE_QUAD, 32'h33, 64'd0);
        tick();
        idle();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL misalign_err got %b want 1", err); end
        repeat (4) tick();
        n_vec++;
        if (mc_rs_vld !== 1'b1 || mc_rs_rtnctl !== 32'h33 || mc_rs_data !== 64'h1008) begin
            n_err++; $display("FAIL misalign_resp got vld %b rtn %h data %h want 1 33 1008", mc_rs_vld, mc_rs_rtnctl, mc_rs_data);
        end
        do_reset();
        drive(3'd7, 48'h40, MC_SIZE_QUAD, 32'h44, 64'd0);
        tick();
        idle();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL badcmd_err got %b want 1", err); end
        seen = 0;
        repeat (8) begin
            tick();
            if (mc_rs_vld === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL badcmd_resp got %0d responses want 0", seen); end
        do_reset();
        drive(AEMC_CMD_RD8, 48'h8, 2'd0, 32'h55, 64'd0);
        tick();
        idle();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL size_err got %b want 1", err); end
        repeat (4) tick();
        n_vec++;
        if (mc_rs_vld !== 1'b1 || mc_rs_data !== 64'h1001) begin
            n_err++; $display("FAIL size_resp got vld %b data %h want 1 1001", mc_rs_vld, mc_rs_data);
        end
        do_reset();
        drive(AEMC_CMD_RD8, 48'hFFFF_0000_0810, MC_SIZE_QUAD, 32'h66, 64'd0);
        tick();
        idle();
        repeat (4) tick();
        n_vec++;
        if (mc_rs_vld !== 1'b1 || mc_rs_data !== 64'h1002 || err !== 1'b0) begin
            n_err++; $display("FAIL wrap_resp got vld %b data %h err %b want 1 1002 0", mc_rs_vld, mc_rs_data, err);
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(AEMC_CMD_RD8, 48'(i * 8), MC_SIZE_QUAD, 32'(32'h300 + i), 64'd0);
            tick();
        end
        idle();
        tick();
        n_vec++; if (mc_rs_vld !== 1'b1) begin n_err++; $display("FAIL midop_pre_vld got %b want 1", mc_rs_vld); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (mc_rs_vld !== 1'b0 || mc_rs_cmd !== 3'd0 || mc_rs_rtnctl !== 32'd0 || mc_rs_data !== 64'd0 ||
            mc_rq_stall !== 1'b0 || err !== 1'b0) begin
            n_err++; $display("FAIL midop_reset got vld %b cmd %0d rtn %h data %h stall %b err %b want all 0",
                              mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl, mc_rs_data, mc_rq_stall, err);
        end
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            if (mc_rs_vld === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midop_stale got %0d responses want 0", seen); end
    endtask

`ifdef MC_RESP_STALL_INJECT_EN
    task automatic test_inject();
        int  found;
        int  got;
        logic prev_stall;
        do_reset();
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            tick();
            if (mc_rq_stall === 1'b1) found = 1;
        end
        n_vec++; if (found !== 1) begin n_err++; $display("FAIL inject_pulse_timeout got none want pulse"); end
        for (int c = 1; c <= 16; c++) begin
            tick();
            n_vec++;
            if (mc_rq_stall !== (c == 1 || c == 16)) begin
                n_err++; $display("FAIL inject_pattern%0d got %b want %b", c, mc_rq_stall, (c == 1 || c == 16));
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(AEMC_CMD_WR8, 48'(i * 8), MC_SIZE_QUAD, 32'd0, 64'(64'h2000 + i));
            tick();
        end
        idle();
        repeat (40) tick();
        for (int i = 0; i < 4; i++) begin
            drive(AEMC_CMD_RD8, 48'(i * 8), MC_SIZE_QUAD, 32'(32'h400 + i), 64'd0);
            tick();
        end
        idle();
        got = 0;
        prev_stall = 1'b0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            tick();
            if (mc_rs_vld === 1'b1) begin
                n_vec++;
                if (prev_stall || mc_rs_rtnctl !== 32'(32'h400 + got) || mc_rs_data !== 64'(64'h2000 + got)) begin
                    n_err++; $display("FAIL inject_resp%0d got rtn %h data %h after_stall %b want %h %h 0",
                                      got, mc_rs_rtnctl, mc_rs_data, prev_stall, 32'h400 + got, 64'h2000 + got);
                end
                got++;
            end
            prev_stall = mc_rq_stall;
        end
        n_vec++; if (got !== 4 || err !== 1'b0) begin n_err++; $display("FAIL inject_count got %0d err %b want 4 0", got, err); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        mc_rs_stall = 1'b0;
        idle();
        test_reset();
`ifdef MC_RESP_STALL_INJECT_EN
        test_inject();
`else
        test_wr_rd();
        test_back_to_back();
        test_err();
        test_reset_midop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
